// File: rtl/fft_readout_sched.sv
// rtl/fft_readout_sched.sv - bit-reversed readout scheduler for the stereo FFT result banks
module fft_readout_sched #(
    parameter int bw_fftp = 4,
    parameter int bw_data = 16
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic               DoneL,
    input  logic               DoneR,
    output logic               RdEn,
    output logic               RdSel,
    output logic [bw_fftp-1:0] RdAddr,
    input  logic [bw_data-1:0] RdData,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [bw_data-1:0] OutData,
    output logic               OutCh,
    output logic               OutFirst,
    output logic               OutLast,
    output logic               ReleaseL,
    output logic               ReleaseR,
    output logic               ErrOvf
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_RELEASE} state_t;

    state_t             state_q, state_d;
    logic               pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic               ptr_q, ptr_d, ch_q, ch_d, err_q, err_d;
    logic [bw_fftp-1:0] idx_q, idx_d;
    logic               infl_q, infl_first_q, infl_last_q, infl_ch_q;

    logic [bw_data-1:0] buf_data_q [2];
    logic [1:0]         buf_ch_q, buf_first_q, buf_last_q;
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         cnt_q;

    logic               pop, buf_wr, buf_rd, grant, gnt_ch, idx_last;
    logic               busy_l, busy_r, ovf_l, ovf_r;
    logic [2:0]         level;
    logic [bw_data-1:0] head_data;
    logic               head_ch, head_first, head_last;

    // The word landing from RAM this cycle is presented directly when the buffer is empty,
    // so level counts buffered + in-flight words after this cycle's pop.
    assign OutValid = (cnt_q != 2'd0) || infl_q;
    assign pop      = OutValid && OutReady;
    assign level    = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    assign idx_last = (idx_q == {bw_fftp{1'b1}});
    assign buf_wr   = infl_q && !((cnt_q == 2'd0) && pop);
    assign buf_rd   = pop && (cnt_q != 2'd0);
    assign RdSel    = ch_q;
    assign ErrOvf   = err_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (pend_l_q || pend_r_q) state_d = S_READ;
            S_READ:    if (RdEn && idx_last) state_d = S_DRAIN;
            S_DRAIN:   if (level == 3'd0) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        RdEn     = 1'b0;
        ReleaseL = 1'b0;
        ReleaseR = 1'b0;
        case (state_q)
            S_READ:    RdEn = (level < 3'd2);
            S_RELEASE: begin
                ReleaseL = !ch_q;
                ReleaseR = ch_q;
            end
            default:   ;
        endcase
    end

    // A bank in RELEASE is already free, so a Done in that cycle is a fresh frame.
    always_comb begin
        grant    = (state_q == S_IDLE) && (pend_l_q || pend_r_q);
        gnt_ch   = (pend_l_q && pend_r_q) ? ptr_q : pend_r_q;
        busy_l   = ((state_q == S_READ) || (state_q == S_DRAIN)) && !ch_q;
        busy_r   = ((state_q == S_READ) || (state_q == S_DRAIN)) && ch_q;
        ovf_l    = DoneL && (pend_l_q || busy_l);
        ovf_r    = DoneR && (pend_r_q || busy_r);
        pend_l_d = (pend_l_q && !(grant && !gnt_ch)) || (DoneL && !ovf_l);
        pend_r_d = (pend_r_q && !(grant && gnt_ch)) || (DoneR && !ovf_r);
        ptr_d    = grant ? !gnt_ch : ptr_q;
        ch_d     = grant ? gnt_ch : ch_q;
        idx_d    = grant ? '0 : (RdEn ? idx_q + bw_fftp'(1) : idx_q);
        err_d    = err_q || ovf_l || ovf_r;
    end

    always_comb begin
        RdAddr = '0;
        for (int j = 0; j < bw_fftp; j++) begin
            RdAddr[j] = idx_q[bw_fftp-1-j];
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pend_l_q     <= 1'b0;
            pend_r_q     <= 1'b0;
            ptr_q        <= 1'b0;
            ch_q         <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            infl_q       <= 1'b0;
            infl_first_q <= 1'b0;
            infl_last_q  <= 1'b0;
            infl_ch_q    <= 1'b0;
        end else begin
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            ptr_q        <= ptr_d;
            ch_q         <= ch_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            infl_q       <= RdEn;
            infl_first_q <= (idx_q == '0);
            infl_last_q  <= idx_last;
            infl_ch_q    <= ch_q;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_ch_q      <= '0;
            buf_first_q   <= '0;
            buf_last_q    <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
        end else begin
            if (buf_wr) begin
                buf_data_q[wr_ptr_q]  <= RdData;
                buf_ch_q[wr_ptr_q]    <= infl_ch_q;
                buf_first_q[wr_ptr_q] <= infl_first_q;
                buf_last_q[wr_ptr_q]  <= infl_last_q;
                wr_ptr_q              <= !wr_ptr_q;
            end
            if (buf_rd) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            case ({buf_wr, buf_rd})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        if (cnt_q != 2'd0) begin
            head_data  = buf_data_q[rd_ptr_q];
            head_ch    = buf_ch_q[rd_ptr_q];
            head_first = buf_first_q[rd_ptr_q];
            head_last  = buf_last_q[rd_ptr_q];
        end else begin
            head_data  = RdData;
            head_ch    = infl_ch_q;
            head_first = infl_first_q;
            head_last  = infl_last_q;
        end
        OutData  = OutValid ? head_data : '0;
        OutCh    = OutValid && head_ch;
        OutFirst = OutValid && head_first;
        OutLast  = OutValid && head_last;
    end

endmodule

// File: tb/tb_fft_readout_sched.sv
// tb/tb_fft_readout_sched.sv - self-checking bench for fft_readout_sched
module tb_fft_readout_sched;

    localparam int BW = 4;
    localparam int N  = 16;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          nRESET = 1'b0;
    logic          DoneL = 1'b0;
    logic          DoneR = 1'b0;
    logic          OutReady = 1'b1;
    logic          RdEn, RdSel, OutValid, OutCh, OutFirst, OutLast, ReleaseL, ReleaseR, ErrOvf;
    logic [BW-1:0] RdAddr;
    logic [DW-1:0] RdData, OutData;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   n_exp = 0;
    logic exp_ch [64];
    int   iss_fi = 0, iss_bin = 0, out_fi = 0, out_bin = 0, rel_fi = 0, outst = 0;
    int   iss_first_c [64], iss_last_c [64], out_first_c [64], out_last_c [64], rel_c [64];
    int   addr_log [N];
    int   addr_tab [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    logic bp_en = 1'b0;

    fft_readout_sched #(.bw_fftp(BW), .bw_data(DW)) dut (
        .CLK(CLK), .nRESET(nRESET), .DoneL(DoneL), .DoneR(DoneR),
        .RdEn(RdEn), .RdSel(RdSel), .RdAddr(RdAddr), .RdData(RdData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutCh(OutCh), .OutFirst(OutFirst), .OutLast(OutLast),
        .ReleaseL(ReleaseL), .ReleaseR(ReleaseR), .ErrOvf(ErrOvf)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_word(input logic ch, input logic [BW-1:0] a);
        return {(ch ? 4'hB : 4'hA), 4'h5, a, ~a};
    endfunction

    always @(posedge CLK) RdData <= RdEn ? mem_word(RdSel, RdAddr) : 16'hDEAD;

    function automatic int bitrev(input int k);
        int r = 0;
        for (int j = 0; j < BW; j++) r = r | (((k >> j) & 1) << (BW - 1 - j));
        return r;
    endfunction

    function automatic logic [28:0] outs_vec();
        return {RdEn, RdSel, RdAddr, OutValid, OutData, OutCh, OutFirst, OutLast,
                ReleaseL, ReleaseR, ErrOvf};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic fail1(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none cycle=%0d", nm, cyc);
    endtask

    task automatic monitor();
        logic             pop;
        logic             prev_stall = 1'b0;
        logic [DW+2:0]    prev_head = '0;
        forever begin
            @(negedge CLK);
            if (!nRESET) begin
                chk("reset_outputs", 64'(outs_vec()), 64'(0));
                iss_fi = n_exp; out_fi = n_exp; rel_fi = n_exp;
                iss_bin = 0; out_bin = 0; outst = 0; prev_stall = 1'b0;
            end else begin
                pop = OutValid && OutReady;
                chk("out_valid", 64'(OutValid), 64'(outst > 0));
                if (prev_stall) chk("head_stable", 64'({OutData, OutCh, OutFirst, OutLast}), 64'(prev_head));
                if (RdEn) begin
                    chk("rd_rule", 64'((outst - int'(pop)) < 2), 64'(1));
                    if (iss_fi >= n_exp) fail1("unexpected_rden");
                    else begin
                        chk("rd_addr", 64'(RdAddr), 64'(bitrev(iss_bin)));
                        chk("rd_sel", 64'(RdSel), 64'(exp_ch[iss_fi]));
                        if (iss_bin == 0) iss_first_c[iss_fi] = cyc;
                        addr_log[iss_bin] = int'(RdAddr);
                        if (iss_bin == N - 1) begin
                            iss_last_c[iss_fi] = cyc; iss_bin = 0; iss_fi++;
                        end else iss_bin++;
                    end
                end
                if (pop) begin
                    if (out_fi >= n_exp) fail1("unexpected_word");
                    else begin
                        chk("out_data", 64'(OutData), 64'(mem_word(exp_ch[out_fi], BW'(bitrev(out_bin)))));
                        chk("out_ch", 64'(OutCh), 64'(exp_ch[out_fi]));
                        chk("out_first", 64'(OutFirst), 64'(out_bin == 0));
                        chk("out_last", 64'(OutLast), 64'(out_bin == N - 1));
                        if (out_bin == 0) out_first_c[out_fi] = cyc;
                        if (out_bin == N - 1) begin
                            out_last_c[out_fi] = cyc; out_bin = 0; out_fi++;
                        end else out_bin++;
                    end
                end
                if (ReleaseL || ReleaseR) begin
                    if (rel_fi >= out_fi) fail1("unexpected_release");
                    else begin
                        chk("release_ch", 64'({ReleaseL, ReleaseR}), 64'(exp_ch[rel_fi] ? 2'b01 : 2'b10));
                        rel_c[rel_fi] = cyc; rel_fi++;
                    end
                end
                outst = outst + int'(RdEn) - int'(pop);
                prev_stall = OutValid && !OutReady;
                prev_head = {OutData, OutCh, OutFirst, OutLast};
            end
        end
    endtask

    task automatic expect_frame(input logic ch);
        exp_ch[n_exp] = ch;
        n_exp++;
    endtask

    task automatic pulse(input logic l, input logic r);
        @(posedge CLK); #1;
        DoneL = l; DoneR = r; c0 = cyc;
        @(posedge CLK); #1;
        DoneL = 1'b0; DoneR = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (rel_fi < n_exp && k < max) begin
            @(posedge CLK); #1;
            if (bp_en) OutReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            k++;
        end
        if (rel_fi < n_exp) fail1("frame_timeout");
        OutReady = 1'b1;
    endtask

    initial begin
        int f;
        int k;
        fork
            monitor();
        join_none
        repeat (3) @(posedge CLK);
        #1 nRESET = 1'b1;
        @(negedge CLK);
        chk("idle_after_reset", 64'(outs_vec()), 64'(0));

        f = n_exp; expect_frame(1'b0); pulse(1'b1, 1'b0); wait_done(60);
        chk("a_first_rden", 64'(iss_first_c[f] - c0), 64'(2));
        chk("a_last_rden", 64'(iss_last_c[f] - c0), 64'(17));
        chk("a_first_out", 64'(out_first_c[f] - c0), 64'(3));
        chk("a_last_out", 64'(out_last_c[f] - c0), 64'(18));
        chk("a_release", 64'(rel_c[f] - c0), 64'(19));
        for (int i = 0; i < N; i++) chk("a_addr_seq", 64'(addr_log[i]), 64'(addr_tab[i]));

        f = n_exp; expect_frame(1'b1); expect_frame(1'b0); pulse(1'b1, 1'b1); wait_done(120);
        chk("b_first_rden", 64'(iss_first_c[f] - c0), 64'(2));
        chk("b_gap", 64'(iss_first_c[f + 1] - iss_last_c[f]), 64'(4));

        f = n_exp; expect_frame(1'b1); pulse(1'b0, 1'b1);
        while (cyc < c0 + 19) begin @(posedge CLK); #1; end
        expect_frame(1'b1); DoneR = 1'b1;
        @(posedge CLK); #1 DoneR = 1'b0;
        wait_done(80);
        chk("c_rel_cycle", 64'(rel_c[f] - c0), 64'(19));
        chk("c_second_rden", 64'(iss_first_c[f + 1] - c0), 64'(21));
        chk("c_no_ovf", 64'(ErrOvf), 64'(0));

        f = n_exp; expect_frame(1'b0); expect_frame(1'b1); pulse(1'b1, 1'b1); wait_done(120);
        chk("d_first_rden", 64'(iss_first_c[f] - c0), 64'(2));
        chk("d_gap", 64'(iss_first_c[f + 1] - iss_last_c[f]), 64'(4));
        chk("d_rel_order", 64'(rel_c[f] < rel_c[f + 1]), 64'(1));

        f = n_exp; bp_en = 1'b1; expect_frame(1'b0); pulse(1'b1, 1'b0); wait_done(200);
        bp_en = 1'b0;
        chk("e_stalled", 64'((out_last_c[f] - c0) > 18), 64'(1));

        chk("f_ovf_before", 64'(ErrOvf), 64'(0));
        expect_frame(1'b0); pulse(1'b1, 1'b0);
        repeat (4) @(posedge CLK);
        pulse(1'b1, 1'b0);
        chk("f_ovf_set", 64'(ErrOvf), 64'(1));
        wait_done(80);
        repeat (40) @(posedge CLK);
        #1 chk("f_ovf_sticky", 64'(ErrOvf), 64'(1));

        expect_frame(1'b0); pulse(1'b1, 1'b0);
        k = 0;
        while (out_bin < 7 && k < 50) begin @(posedge CLK); #1; k++; end
        if (out_bin < 7) fail1("g_word7_timeout");
        #1 nRESET = 1'b0;
        #1 chk("g_reset_outputs", 64'(outs_vec()), 64'(0));
        repeat (2) @(posedge CLK);
        #1 nRESET = 1'b1;
        repeat (25) @(posedge CLK);
        f = n_exp; expect_frame(1'b1); pulse(1'b0, 1'b1); wait_done(60);
        chk("g_first_out", 64'(out_first_c[f] - c0), 64'(3));
        chk("g_ovf_cleared", 64'(ErrOvf), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
